// File: rtl/ahfp_addsub_arbiter_if.sv
// rtl/ahfp_addsub_arbiter_if.sv - requester-side request/response bundle for the fp add/sub arbiter
interface ahfp_addsub_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_op;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [32*NUM_REQ-1:0] req_datab;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;

  // Requesters drive operands and consume grants/results
  modport master (
    output req_valid, req_op, req_dataa, req_datab,
    input  req_ready, resp_valid, resp_data
  );

  // The arbiter consumes operands and produces grants/results
  modport slave (
    input  req_valid, req_op, req_dataa, req_datab,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ahfp_addsub_arbiter.sv
// rtl/ahfp_addsub_arbiter.sv - round-robin sharing of one pipelined fp add/sub unit
module ahfp_addsub_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FU_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ahfp_addsub_arbiter_if.slave bus,
  output logic [31:0]          fu_dataa,
  output logic [31:0]          fu_datab,
  input  logic [31:0]          fu_result,
  output logic                 idle,
  output logic [CNT_W-1:0]     issue_count
);
  localparam int PW    = $clog2(NUM_REQ);
  // One issue register plus FU_LATENCY unit stages; the last stage lines up with fu_result.
  localparam int DEPTH = FU_LATENCY + 1;

  logic [PW-1:0]      ptr;
  logic [PW:0]        cand;
  logic [PW-1:0]      grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               sel_op;
  logic [DEPTH-1:0]   tag_v;
  logic [PW-1:0]      tag_own [DEPTH];

  // Pick the first valid requester after the last one granted, wrapping around
  always_comb begin
    cand      = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!grant_any && bus.req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  // One-hot ready, forced off while reset is held
  always_comb begin
    grant = '0;
    if (!reset && grant_any) grant[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign xfer          = !reset && grant_any;

  // Operand mux for the granted requester; subtraction is a sign flip of B
  always_comb begin
    sel_a  = bus.req_dataa[32*grant_idx +: 32];
    sel_op = bus.req_op[grant_idx];
    sel_b  = bus.req_datab[32*grant_idx +: 32];
    if (sel_op) sel_b = {~sel_b[31], sel_b[30:0]};
  end

  // Issue register, rr pointer, counter and owner tag pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= PW'(NUM_REQ-1);
      fu_dataa    <= '0;
      fu_datab    <= '0;
      issue_count <= '0;
      tag_v       <= '0;
      for (int s = 0; s < DEPTH; s++) tag_own[s] <= '0;
    end else begin
      tag_v      <= {tag_v[DEPTH-2:0], xfer};
      tag_own[0] <= grant_idx;
      for (int s = 1; s < DEPTH; s++) tag_own[s] <= tag_own[s-1];
      if (xfer) begin
        fu_dataa    <= sel_a;
        fu_datab    <= sel_b;
        ptr         <= grant_idx;
        issue_count <= issue_count + CNT_W'(1);
      end else begin
        fu_dataa <= '0;
        fu_datab <= '0;
      end
    end
  end

  // Route the unit result back to the owner recorded in the last tag stage
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (tag_v[DEPTH-1]) begin
        bus.resp_valid[tag_own[DEPTH-1]] <= 1'b1;
        bus.resp_data                    <= fu_result;
      end
    end
  end

  assign idle = ~|tag_v;
endmodule

// File: tb/tb_ahfp_addsub_arbiter.sv
// tb/tb_ahfp_addsub_arbiter.sv - self-checking bench for the fp add/sub arbiter
module tb_ahfp_addsub_arbiter;
  logic        clk;
  logic        reset;
  logic [31:0] fu_dataa, fu_datab, fu_result;
  logic        idle;
  logic [15:0] issue_count;
  logic [31:0] fu_dataa2, fu_datab2;
  logic [31:0] fu_result2;
  logic        idle2;
  logic [3:0]  issue_count2;

  ahfp_addsub_arbiter_if #(.NUM_REQ(4)) bus ();
  ahfp_addsub_arbiter_if #(.NUM_REQ(4)) bus2 ();

  ahfp_addsub_arbiter #(.NUM_REQ(4), .FU_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fu_dataa(fu_dataa), .fu_datab(fu_datab), .fu_result(fu_result),
    .idle(idle), .issue_count(issue_count)
  );

  ahfp_addsub_arbiter #(.NUM_REQ(4), .FU_LATENCY(1), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .bus(bus2),
    .fu_dataa(fu_dataa2), .fu_datab(fu_datab2), .fu_result(fu_result2),
    .idle(idle2), .issue_count(issue_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // float32 <-> real, exact for normal numbers and zero
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:23] == 8'd0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], e[10:0], f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'b0};
    e = e - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Shared unit stand-in: one-cycle latency adder
  always @(posedge clk) fu_result <= r2f(f2r(fu_dataa) + f2r(fu_datab));
  assign fu_result2 = 32'h0;

  typedef struct {
    int          owner;
    logic [31:0] val;
    int          due;
  } resp_t;

  resp_t       m_q[$];
  int          m_last;
  int          m_cyc;
  int          m_cnt;
  logic [31:0] m_rd;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] slot(input int i, input logic [31:0] w);
    logic [127:0] r;
    r = '0;
    r[32*i +: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] rnd_f();
    int k;
    k = int'($urandom_range(200)) - 100;
    return r2f(real'(k));
  endfunction

  // One clock of stimulus with full comparison against the reference model
  task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] op,
                      input logic [127:0] a, input logic [127:0] b, output logic [3:0] rdy);
    int          g;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_rv;
    logic [31:0] exp_fa, exp_fb, bb;
    real         rv;
    reset         = rst;
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_dataa = a;
    bus.req_datab = b;
    #1;
    g = -1;
    if (!rst)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    rdy = bus.req_ready;
    chk("req_ready", 64'(rdy), 64'(exp_rdy));
    @(posedge clk);
    #1;
    m_cyc++;
    exp_fa = '0;
    exp_fb = '0;
    if (rst) begin
      m_q.delete();
      m_last = 3;
      m_cnt  = 0;
      m_rd   = '0;
    end else if (g >= 0) begin
      exp_fa = a[32*g +: 32];
      bb     = b[32*g +: 32];
      exp_fb = op[g] ? {~bb[31], bb[30:0]} : bb;
      rv     = op[g] ? f2r(exp_fa) - f2r(bb) : f2r(exp_fa) + f2r(bb);
      m_q.push_back('{owner: g, val: r2f(rv), due: m_cyc + 2});
      m_last = g;
      m_cnt++;
    end
    exp_rv = '0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      exp_rv = 4'b0001 << m_q[0].owner;
      m_rd   = m_q[0].val;
      void'(m_q.pop_front());
    end
    chk("fu_dataa", 64'(fu_dataa), 64'(exp_fa));
    chk("fu_datab", 64'(fu_datab), 64'(exp_fb));
    chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    chk("resp_data", 64'(bus.resp_data), 64'(m_rd));
    chk("issue_count", 64'(issue_count), 64'(m_cnt % 65536));
    chk("idle", 64'(idle), 64'(m_q.size() == 0));
  endtask

  initial begin
    logic [3:0]   r;
    logic [127:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    m_cyc    = 0;
    m_last   = 3;
    m_cnt    = 0;
    m_rd     = '0;
    reset    = 1'b1;
    bus.req_valid  = '0; bus.req_op  = '0; bus.req_dataa  = '0; bus.req_datab  = '0;
    bus2.req_valid = '0; bus2.req_op = '0; bus2.req_dataa = '0; bus2.req_datab = '0;

    // Reset state
    step(1'b1, 4'b0000, 4'b0000, '0, '0, r);
    step(1'b1, 4'b1111, 4'b0000, '0, '0, r);
    chk("reset_ready", 64'(r), 64'd0);

    // Single add on requester 0: 1.0 + 2.0
    step(1'b0, 4'b0001, 4'b0000, slot(0, 32'h3F800000), slot(0, 32'h40000000), r);
    chk("add_ready", 64'(r), 64'h1);
    chk("add_fu_datab", 64'(fu_datab), 64'h40000000);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("add_busy", 64'(idle), 64'd0);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("add_resp_valid", 64'(bus.resp_valid), 64'h1);
    chk("add_resp_data", 64'(bus.resp_data), 64'h40400000);
    chk("add_idle", 64'(idle), 64'd1);

    // Subtract on requester 2: 3.0 - 1.0
    step(1'b0, 4'b0100, 4'b0100, slot(2, 32'h40400000), slot(2, 32'h3F800000), r);
    chk("sub_fu_datab", 64'(fu_datab), 64'hBF800000);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("sub_resp_valid", 64'(bus.resp_valid), 64'h4);
    chk("sub_resp_data", 64'(bus.resp_data), 64'h40000000);
    chk("hold_check_pre", 64'(bus.resp_data), 64'h40000000);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("resp_data_hold", 64'(bus.resp_data), 64'h40000000);

    // Counter wrap on the 4-bit instance: 17 transfers
    step(1'b1, 4'b0000, 4'b0000, '0, '0, r);
    bus2.req_valid = 4'b0001;
    for (int n = 0; n < 17; n++) begin
      ra = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      rb = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      step(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), ra, rb, r);
    end
    bus2.req_valid = 4'b0000;
    chk("wrap_count", 64'(issue_count2), 64'd1);

    // Round robin with all requesters valid
    step(1'b1, 4'b0000, 4'b0000, '0, '0, r);
    for (int n = 0; n < 8; n++) begin
      ra = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      rb = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      step(1'b0, 4'b1111, 4'($urandom_range(15)), ra, rb, r);
      chk("rr_grant", 64'(r), 64'(4'b0001 << (n % 4)));
    end
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("rr_count", 64'(issue_count), 64'd8);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    chk("rr_last_resp", 64'(bus.resp_valid), 64'h8);

    // Pointer skip: grant to 1, then only 0 and 3 valid
    step(1'b0, 4'b0010, 4'b0000, slot(1, 32'h3F800000), slot(1, 32'h3F800000), r);
    chk("skip_g1", 64'(r), 64'h2);
    step(1'b0, 4'b1001, 4'b0000, {32'h40000000, 64'h0, 32'h3F800000}, {32'h40000000, 64'h0, 32'h3F800000}, r);
    chk("skip_g3", 64'(r), 64'h8);
    step(1'b0, 4'b1001, 4'b0000, {32'h40000000, 64'h0, 32'h3F800000}, {32'h40000000, 64'h0, 32'h3F800000}, r);
    chk("skip_g0", 64'(r), 64'h1);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
    step(1'b0, 4'b0000, 4'b0000, '0, '0, r);

    // Reset while an op for requester 1 is in flight
    step(1'b0, 4'b0010, 4'b0000, slot(1, 32'h40400000), slot(1, 32'h40400000), r);
    step(1'b1, 4'b0010, 4'b0000, '0, '0, r);
    chk("mid_reset_count", 64'(issue_count), 64'd0);
    chk("mid_reset_idle", 64'(idle), 64'd1);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 4'b0000, 4'b0000, '0, '0, r);
      chk("mid_reset_noresp", 64'(bus.resp_valid), 64'd0);
    end
    step(1'b0, 4'b1010, 4'b0000, slot(3, 32'h3F800000) | slot(1, 32'h3F800000), '0, r);
    chk("post_reset_grant", 64'(r), 64'h2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 200; n++) begin
      ra = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      rb = {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
      step($urandom_range(24) == 0, 4'($urandom_range(15)), 4'($urandom_range(15)), ra, rb, r);
    end
    for (int n = 0; n < 3; n++) step(1'b0, 4'b0000, 4'b0000, '0, '0, r);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
